// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Purpose:
//   Owns the program counter of the pipelined MIPS core and runs the
//   request/acknowledge handshake with instruction memory. The next PC comes
//   from one of four sources: sequential (pc+4), branch, jump or the
//   exception vector. PC is held while the hazard unit stalls. Redirects
//   that arrive while a fetch is outstanding are remembered and applied when
//   that fetch completes; the word returned by that fetch is then dropped.
//   A fetch that is never acknowledged is abandoned after MAX_WAIT cycles,
//   and fetching restarts at the exception vector.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   EXC_VECTOR    PC loaded on exception or fetch timeout
//   MAX_WAIT      cycles of unacknowledged request before timeout (>= 2)
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_stall          hazard unit: hold PC, issue no new fetch
//   i_branch_taken   1-cycle pulse: redirect to i_branch_target
//   i_branch_target  branch target address
//   i_jump           1-cycle pulse: redirect to i_jump_target
//   i_jump_target    jump target address
//   i_exception      1-cycle pulse: redirect to EXC_VECTOR
//   o_pc             current fetch address (registered), drives imem address
//   o_fetch_req      fetch request to imem (registered)
//   i_fetch_ack      imem: instruction for o_pc is valid this cycle
//   o_fetch_valid    1-cycle pulse: fetched word is kept in IF/ID
//   o_inst_pc        PC of the word flagged by o_fetch_valid
//   o_timeout_err    1-cycle pulse when a fetch times out
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          MAX_WAIT     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exception,
  output logic [31:0] o_pc,
  output logic        o_fetch_req,
  input  logic        i_fetch_ack,
  output logic        o_fetch_valid,
  output logic [31:0] o_inst_pc,
  output logic        o_timeout_err
);

  localparam int             CW        = $clog2(MAX_WAIT);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [31:0]    ALIGN     = 32'hFFFF_FFFC;

  // Redirect priority encoding; a larger value wins.
  localparam logic [1:0] PRIO_NONE   = 2'd0;
  localparam logic [1:0] PRIO_BRANCH = 2'd1;
  localparam logic [1:0] PRIO_JUMP   = 2'd2;
  localparam logic [1:0] PRIO_EXC    = 2'd3;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_STALL,
    S_RECOVER
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic          r_fetch_req;
  logic          r_fetch_valid;
  logic [31:0]   r_inst_pc;
  logic          r_timeout_err;
  logic [1:0]    r_pend_prio;
  logic [31:0]   r_pend_target;
  logic [CW-1:0] r_wait_cnt;

  logic [1:0]    w_new_prio;
  logic [31:0]   w_new_target;
  logic          w_take_new;
  logic          w_redir_valid;
  logic [1:0]    w_redir_prio;
  logic [31:0]   w_redir_target;

  // Highest-priority redirect requested this cycle. Targets are word
  // aligned by clearing the two low address bits.
  always_comb begin
    w_new_prio   = PRIO_NONE;
    w_new_target = 32'h0;
    if (i_exception) begin
      w_new_prio   = PRIO_EXC;
      w_new_target = EXC_VECTOR & ALIGN;
    end else if (i_jump) begin
      w_new_prio   = PRIO_JUMP;
      w_new_target = i_jump_target & ALIGN;
    end else if (i_branch_taken) begin
      w_new_prio   = PRIO_BRANCH;
      w_new_target = i_branch_target & ALIGN;
    end
  end

  // Merge this cycle's redirect with the pending one: a new redirect of
  // equal or higher priority replaces the pending one, a lower one is lost.
  assign w_take_new     = (w_new_prio != PRIO_NONE) && (w_new_prio >= r_pend_prio);
  assign w_redir_valid  = w_take_new || (r_pend_prio != PRIO_NONE);
  assign w_redir_prio   = w_take_new ? w_new_prio   : r_pend_prio;
  assign w_redir_target = w_take_new ? w_new_target : r_pend_target;

  // Sequencer FSM. Every output is a register updated here so imem sees a
  // glitch-free address and request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_req   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_inst_pc     <= 32'h0;
      r_timeout_err <= 1'b0;
      r_pend_prio   <= PRIO_NONE;
      r_pend_target <= 32'h0;
      r_wait_cnt    <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_timeout_err <= 1'b0;

      case (r_state)
        // Single settling cycle after reset; redirects and acks ignored.
        S_BOOT: begin
          r_state     <= S_FETCH;
          r_fetch_req <= 1'b1;
          r_wait_cnt  <= '0;
        end

        // Request is outstanding; o_pc must not move until it is answered.
        S_FETCH: begin
          if (i_fetch_ack) begin
            r_wait_cnt    <= '0;
            r_pend_prio   <= PRIO_NONE;
            r_pend_target <= 32'h0;
            if (w_redir_valid) begin
              r_pc <= w_redir_target;
            end else begin
              r_pc          <= r_pc + 32'd4;
              r_inst_pc     <= r_pc;
              r_fetch_valid <= 1'b1;
            end
            if (i_stall) begin
              r_state     <= S_STALL;
              r_fetch_req <= 1'b0;
            end else begin
              r_state     <= S_FETCH;
              r_fetch_req <= 1'b1;
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            // Memory never answered: abandon the fetch, drop any pending
            // redirect and restart at the exception vector.
            r_timeout_err <= 1'b1;
            r_pc          <= EXC_VECTOR & ALIGN;
            r_fetch_req   <= 1'b0;
            r_pend_prio   <= PRIO_NONE;
            r_pend_target <= 32'h0;
            r_wait_cnt    <= '0;
            r_state       <= S_RECOVER;
          end else begin
            r_wait_cnt    <= r_wait_cnt + CW'(1);
            r_pend_prio   <= w_redir_prio;
            r_pend_target <= w_redir_target;
          end
        end

        // No request outstanding, so a redirect can load o_pc at once. An
        // exception forces fetching to resume even if the stall is held.
        // RECOVER lasts one cycle and then behaves like a stall release.
        S_STALL, S_RECOVER: begin
          r_wait_cnt <= '0;
          if (w_new_prio != PRIO_NONE) begin
            r_pc <= w_new_target;
          end
          if (i_exception || !i_stall) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end else begin
            r_state     <= S_STALL;
            r_fetch_req <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_BOOT;
          r_fetch_req <= 1'b0;
          r_wait_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_fetch_req   = r_fetch_req;
  assign o_fetch_valid = r_fetch_valid;
  assign o_inst_pc     = r_inst_pc;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Purpose:
//   Self-checking bench for pc_fetch_sequencer. Each scenario task drives
//   the hazard/branch inputs and the imem acknowledge and compares o_pc,
//   o_fetch_req and o_timeout_err inline. Every acknowledge that should
//   produce a kept word pushes the expected instruction PC into a queue;
//   a monitor pops it whenever o_fetch_valid pulses, so a dropped word that
//   is wrongly kept (or a kept word that goes missing) is caught.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_exception;
  logic [31:0] o_pc;
  logic        o_fetch_req;
  logic        i_fetch_ack;
  logic        o_fetch_valid;
  logic [31:0] o_inst_pc;
  logic        o_timeout_err;

  int          errors;
  int          checks;
  logic [31:0] expQ[$];
  logic [31:0] expPc;

  pc_fetch_sequencer dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_exception     (i_exception),
    .o_pc            (o_pc),
    .o_fetch_req     (o_fetch_req),
    .i_fetch_ack     (i_fetch_ack),
    .o_fetch_valid   (o_fetch_valid),
    .o_inst_pc       (o_inst_pc),
    .o_timeout_err   (o_timeout_err)
  );

  // 10-time-unit clock; rising edges at 5, 15, ...
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Scoreboard consumer: each kept word must match the oldest expectation.
  always @(negedge i_clk) begin
    if (o_fetch_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_keep: got kept word inst_pc=%h, required no kept word", o_inst_pc);
      end else begin
        expPc = expQ.pop_front();
        if (o_inst_pc !== expPc) begin
          errors++;
          $display("[TB] FAIL sb_inst_pc: got %h, required %h", o_inst_pc, expPc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Resets the DUT and returns at a falling edge with the first fetch of
  // address 0 outstanding.
  task automatic do_reset();
    i_stall         = 1'b0;
    i_branch_taken  = 1'b0;
    i_branch_target = 32'h0;
    i_jump          = 1'b0;
    i_jump_target   = 32'h0;
    i_exception     = 1'b0;
    i_fetch_ack     = 1'b0;
    #2 i_rst_n = 1'b0;
    tick();
    tick();
    #2 i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL boot_req: got %b, required 1", o_fetch_req); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL boot_pc: got %h, required 00000000", o_pc); end
    i_fetch_ack = 1'b1;
    expQ.push_back(32'h0); tick();
    checks++; if (o_pc !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc4: got %h, required 00000004", o_pc); end
    expQ.push_back(32'h4); tick();
    checks++; if (o_pc !== 32'h8) begin errors++; $display("[TB] FAIL seq_pc8: got %h, required 00000008", o_pc); end
    // Reset asserted in the middle of back-to-back fetching.
    #2 i_rst_n = 1'b0;
    i_fetch_ack = 1'b0;
    #1;
    checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h, required 00000000", o_pc); end
    checks++; if (o_fetch_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b, required 0", o_fetch_req); end
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b, required 0", o_fetch_valid); end
    checks++; if (o_inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst_pc: got %h, required 00000000", o_inst_pc); end
    checks++; if (o_timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b, required 0", o_timeout_err); end
    tick();
    checks++; if (o_fetch_req !== 1'b0 || o_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_hold: got req=%b pc=%h, required req=0 pc=00000000", o_fetch_req, o_pc); end
    #2 i_rst_n = 1'b1;
    #1;
    checks++; if (o_fetch_req !== 1'b0) begin errors++; $display("[TB] FAIL release_req: got %b, required 0", o_fetch_req); end
    tick();
    checks++; if (o_fetch_req !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("[TB] FAIL release_fetch: got req=%b pc=%h, required req=1 pc=00000000", o_fetch_req, o_pc); end
    i_fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(32'(4 * i));
      tick();
      checks++; if (o_pc !== 32'(4 * (i + 1))) begin errors++; $display("[TB] FAIL b2b_pc%0d: got %h, required %h", i, o_pc, 32'(4 * (i + 1))); end
    end
    i_fetch_ack = 1'b0;
  endtask

  task automatic test_late_ack_branch();
    do_reset();
    i_branch_taken  = 1'b1;
    i_branch_target = 32'h100;
    tick();
    i_branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_pc !== 32'h0 || o_fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL late_hold%0d: got pc=%h req=%b, required pc=00000000 req=1", i, o_pc, o_fetch_req); end
      tick();
    end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL late_hold2: got %h, required 00000000", o_pc); end
    i_fetch_ack = 1'b1;
    tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h100) begin errors++; $display("[TB] FAIL late_branch_pc: got %h, required 00000100", o_pc); end
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_drop: got %b, required 0", o_fetch_valid); end
    i_fetch_ack = 1'b1;
    expQ.push_back(32'h100);
    tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h104) begin errors++; $display("[TB] FAIL late_next: got %h, required 00000104", o_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    i_fetch_ack = 1'b1;
    expQ.push_back(32'h0); tick();
    expQ.push_back(32'h4); tick();
    i_stall = 1'b1;
    expQ.push_back(32'h8); tick();
    i_fetch_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_fetch_req !== 1'b0 || o_pc !== 32'hC) begin errors++; $display("[TB] FAIL stall_hold%0d: got req=%b pc=%h, required req=0 pc=0000000c", i, o_fetch_req, o_pc); end
      // A stray ack while no request is out must be ignored.
      i_fetch_ack = (i == 1);
      if (i == 3) i_stall = 1'b0;
      tick();
    end
    i_fetch_ack = 1'b0;
    checks++; if (o_fetch_req !== 1'b1 || o_pc !== 32'hC) begin errors++; $display("[TB] FAIL stall_resume: got req=%b pc=%h, required req=1 pc=0000000c", o_fetch_req, o_pc); end
    i_fetch_ack = 1'b1;
    expQ.push_back(32'hC); tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h10) begin errors++; $display("[TB] FAIL stall_next: got %h, required 00000010", o_pc); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    i_stall = 1'b1;
    i_fetch_ack = 1'b1;
    expQ.push_back(32'h0); tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h4 || o_fetch_req !== 1'b0) begin errors++; $display("[TB] FAIL sr_stall: got pc=%h req=%b, required pc=00000004 req=0", o_pc, o_fetch_req); end
    i_branch_taken = 1'b1;
    i_branch_target = 32'h205;
    tick();
    i_branch_taken = 1'b0;
    checks++; if (o_pc !== 32'h204 || o_fetch_req !== 1'b0) begin errors++; $display("[TB] FAIL sr_branch: got pc=%h req=%b, required pc=00000204 req=0", o_pc, o_fetch_req); end
    i_exception = 1'b1;
    tick();
    i_exception = 1'b0;
    checks++; if (o_pc !== EXC || o_fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL sr_exc: got pc=%h req=%b, required pc=%h req=1", o_pc, o_fetch_req, EXC); end
    i_stall = 1'b0;
    i_fetch_ack = 1'b1;
    expQ.push_back(EXC); tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== EXC + 32'd4) begin errors++; $display("[TB] FAIL sr_next: got %h, required %h", o_pc, EXC + 32'd4); end
  endtask

  task automatic test_priority();
    do_reset();
    i_exception = 1'b1; i_jump = 1'b1; i_branch_taken = 1'b1;
    i_jump_target = 32'h400; i_branch_target = 32'h200;
    tick();
    i_exception = 1'b0; i_jump = 1'b0;
    i_branch_target = 32'h600;
    checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL prio_hold: got %h, required 00000000", o_pc); end
    tick();
    i_branch_taken = 1'b0;
    i_fetch_ack = 1'b1;
    tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== EXC) begin errors++; $display("[TB] FAIL prio_exc: got %h, required %h", o_pc, EXC); end
    checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_drop: got %b, required 0", o_fetch_valid); end
    // Pending branch overridden by a later jump.
    i_branch_taken = 1'b1; i_branch_target = 32'h300;
    tick();
    i_branch_taken = 1'b0;
    i_jump = 1'b1; i_jump_target = 32'h500;
    tick();
    i_jump = 1'b0;
    i_fetch_ack = 1'b1;
    tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h500) begin errors++; $display("[TB] FAIL prio_jump: got %h, required 00000500", o_pc); end
    // Pending branch replaced by an equal-priority branch in the ack cycle.
    i_branch_taken = 1'b1; i_branch_target = 32'h700;
    tick();
    i_branch_target = 32'h800;
    i_fetch_ack = 1'b1;
    tick();
    i_branch_taken = 1'b0;
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h800) begin errors++; $display("[TB] FAIL prio_equal: got %h, required 00000800", o_pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (o_timeout_err !== 1'b0 || o_fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL to_wait_a%0d: got err=%b req=%b, required err=0 req=1", i, o_timeout_err, o_fetch_req); end
    end
    i_fetch_ack = 1'b1;
    expQ.push_back(32'h0); tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h4 || o_timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_ack_clear: got pc=%h err=%b, required pc=00000004 err=0", o_pc, o_timeout_err); end
    for (int i = 0; i < 7; i++) begin
      i_branch_taken = (i == 0);
      i_branch_target = 32'h900;
      tick();
      checks++; if (o_timeout_err !== 1'b0 || o_pc !== 32'h4) begin errors++; $display("[TB] FAIL to_wait_b%0d: got err=%b pc=%h, required err=0 pc=00000004", i, o_timeout_err, o_pc); end
    end
    i_branch_taken = 1'b0;
    tick();
    checks++; if (o_timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %b, required 1", o_timeout_err); end
    checks++; if (o_pc !== EXC || o_fetch_req !== 1'b0) begin errors++; $display("[TB] FAIL to_recover: got pc=%h req=%b, required pc=%h req=0", o_pc, o_fetch_req, EXC); end
    tick();
    checks++; if (o_timeout_err !== 1'b0 || o_fetch_req !== 1'b1 || o_pc !== EXC) begin errors++; $display("[TB] FAIL to_refetch: got err=%b req=%b pc=%h, required err=0 req=1 pc=%h", o_timeout_err, o_fetch_req, o_pc, EXC); end
    i_fetch_ack = 1'b1;
    expQ.push_back(EXC); tick();
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== EXC + 32'd4) begin errors++; $display("[TB] FAIL to_next: got %h, required %h", o_pc, EXC + 32'd4); end
  endtask

  task automatic test_wrap();
    do_reset();
    i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFF;
    tick();
    i_jump = 1'b0;
    i_fetch_ack = 1'b1;
    tick();
    checks++; if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_load: got %h, required fffffffc", o_pc); end
    expQ.push_back(32'hFFFF_FFFC); tick();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h, required 00000000", o_pc); end
    checks++; if (o_inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_inst_pc: got %h, required fffffffc", o_inst_pc); end
    i_jump = 1'b1; i_jump_target = 32'h403;
    tick();
    i_jump = 1'b0;
    i_fetch_ack = 1'b0;
    checks++; if (o_pc !== 32'h400) begin errors++; $display("[TB] FAIL wrap_align: got %h, required 00000400", o_pc); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    i_branch_taken = 1'b0;
    i_branch_target = 32'h0;
    i_jump = 1'b0;
    i_jump_target = 32'h0;
    i_exception = 1'b0;
    i_fetch_ack = 1'b0;
    test_reset();
    test_late_ack_branch();
    test_stall();
    test_stall_redirect();
    test_priority();
    test_timeout();
    test_wrap();
    tick();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d kept words still expected, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
